options_parser_arbiter: RTL

Round-robin arbiter that shares one OptionsParser instance between two requesters. Each requester hands over a 15-byte option-field block. The arbiter forwards that block to the parser's `fieldsIn` channel, collects the `parsedOut` result, and returns the result to the same requester. It sits between the two header-extraction front ends and the single parser, and serialises them one transaction at a time.

---
 rtl/options_parser_arbiter.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/options_parser_arbiter.sv
// Round-robin arbiter that shares one OptionsParser between two requesters, one transaction at a time.
// Optional WAIT timeout and sticky FAULT state are enabled by defining OPTIONS_PARSER_ARB_TIMEOUT_EN.
module options_parser_arbiter #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int PARSED_W       = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [119:0]        req0_sig,
  input  logic                req0_sync,
  output logic                req0_notify,
  input  logic [119:0]        req1_sig,
  input  logic                req1_sync,
  output logic                req1_notify,
  output logic [PARSED_W-1:0] rsp0_sig,
  input  logic                rsp0_sync,
  output logic                rsp0_notify,
  output logic [PARSED_W-1:0] rsp1_sig,
  input  logic                rsp1_sync,
  output logic                rsp1_notify,
  output logic [119:0]        par_fields_sig,
  output logic                par_fields_notify,
  input  logic                par_fields_sync,
  input  logic [PARSED_W-1:0] par_parsed_sig,
  input  logic                par_parsed_sync,
  output logic                par_parsed_notify,
  output logic                grant,
  output logic                busy,
  output logic                timeout_err
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] TAKE  = 3'd1;
  localparam logic [2:0] SEND  = 3'd2;
  localparam logic [2:0] WAIT  = 3'd3;
  localparam logic [2:0] REPLY = 3'd4;
`ifdef OPTIONS_PARSER_ARB_TIMEOUT_EN
  localparam logic [2:0] FAULT = 3'd5;
`endif

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be in 1..65535");
  end

  logic [2:0]          state_q, state_d;
  logic                grant_q, grant_d;
  logic                last_served_q, last_served_d;
  logic [119:0]        fields_buf_q, fields_buf_d;
  logic [PARSED_W-1:0] parsed_buf_q, parsed_buf_d;
  logic                take_sync, reply_sync;

`ifdef OPTIONS_PARSER_ARB_TIMEOUT_EN
  logic [15:0] wait_cnt_q, wait_cnt_d;
`endif

  assign take_sync  = grant_q ? req1_sync : req0_sync;
  assign reply_sync = grant_q ? rsp1_sync : rsp0_sync;

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    last_served_d = last_served_q;
    fields_buf_d  = fields_buf_q;
    parsed_buf_d  = parsed_buf_q;
`ifdef OPTIONS_PARSER_ARB_TIMEOUT_EN
    wait_cnt_d    = wait_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        // Ties go to whoever was not served last; single requests win outright.
        if (req0_sync && req1_sync) begin
          grant_d = ~last_served_q;
          state_d = TAKE;
        end else if (req0_sync) begin
          grant_d = 1'b0;
          state_d = TAKE;
        end else if (req1_sync) begin
          grant_d = 1'b1;
          state_d = TAKE;
        end
      end
      TAKE: begin
        if (take_sync) begin
          fields_buf_d = grant_q ? req1_sig : req0_sig;
          state_d      = SEND;
        end
      end
      SEND: begin
        if (par_fields_sync) begin
`ifdef OPTIONS_PARSER_ARB_TIMEOUT_EN
          wait_cnt_d = 16'd0;
`endif
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (par_parsed_sync) begin
          parsed_buf_d = par_parsed_sig;
          state_d      = REPLY;
        end else begin
`ifdef OPTIONS_PARSER_ARB_TIMEOUT_EN
          if (wait_cnt_q == 16'(TIMEOUT_CYCLES - 1)) state_d = FAULT;
          else wait_cnt_d = wait_cnt_q + 16'd1;
`endif
        end
      end
      REPLY: begin
        if (reply_sync) begin
          last_served_d = grant_q;
          state_d       = IDLE;
        end
      end
`ifdef OPTIONS_PARSER_ARB_TIMEOUT_EN
      FAULT: state_d = FAULT;
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      grant_q       <= 1'b0;
      last_served_q <= 1'b1;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      last_served_q <= last_served_d;
    end
  end

`ifdef OPTIONS_PARSER_ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) wait_cnt_q <= 16'd0;
    else      wait_cnt_q <= wait_cnt_d;
  end
`endif

  // Data buffers carry no reset; every output that exposes them is gated by state.
  always_ff @(posedge clk) begin
    fields_buf_q <= fields_buf_d;
    parsed_buf_q <= parsed_buf_d;
  end

  assign req0_notify       = (state_q == TAKE)  && !grant_q;
  assign req1_notify       = (state_q == TAKE)  &&  grant_q;
  assign par_fields_notify = (state_q == SEND);
  assign par_parsed_notify = (state_q == WAIT);
  assign rsp0_notify       = (state_q == REPLY) && !grant_q;
  assign rsp1_notify       = (state_q == REPLY) &&  grant_q;

  assign par_fields_sig = par_fields_notify ? fields_buf_q : '0;
  assign rsp0_sig       = rsp0_notify ? parsed_buf_q : '0;
  assign rsp1_sig       = rsp1_notify ? parsed_buf_q : '0;

  assign grant = grant_q;
  assign busy  = (state_q != IDLE);
`ifdef OPTIONS_PARSER_ARB_TIMEOUT_EN
  assign timeout_err = (state_q == FAULT);
`else
  assign timeout_err = 1'b0;
`endif

endmodule
